// File: rtl/lsu.sv
// Load/store unit: takes one memory op from ex, runs it on the data bus, and writes load results back to regs.
// Optional bus timeout is enabled with `define LSU_TIMEOUT_EN; without it BUSY waits indefinitely for mem_ready.
`ifndef XLEN_WIDTH
`define XLEN_WIDTH 32
`endif

module lsu #(
    parameter int XLEN    = `XLEN_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            pause,
    output logic            regs_write_en,
    output logic [4:0]      regs_write_addr,
    output logic [XLEN-1:0] regs_write_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            misalign_err,
    output logic            bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_write;
    logic            r_err;
    logic            w_legal;
    logic            w_timeout;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_bus_err;
`else
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT == 0);
`endif

    // Legality is judged on the live request so the IDLE decision needs no extra cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_legal = 1'b0;
        case (req_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~req_addr[0];
            3'b010:  w_legal = (req_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~req_write;
            3'b101:  w_legal = ~req_write & ~req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_timeout = 1'b0;
`ifdef LSU_TIMEOUT_EN
        w_timeout = (r_state == S_BUSY) && !mem_ready && (r_cnt == CW'(TIMEOUT - 1));
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_legal ? S_BUSY : S_DONE;
            S_BUSY:  if (mem_ready || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_rd     <= req_rd;
                r_write  <= req_write;
                r_err    <= ~w_legal;
            end
            if (r_state == S_BUSY && mem_ready) r_rdata <= mem_rdata;
`ifdef LSU_TIMEOUT_EN
            if (r_state == S_IDLE) begin
                r_cnt     <= '0;
                r_bus_err <= 1'b0;
            end else if (r_state == S_BUSY && !mem_ready) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_timeout) r_bus_err <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = r_rdata[7:0];
            2'b01:   w_byte = r_rdata[15:8];
            2'b10:   w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = r_rdata;
        endcase
    end

    always_comb begin
        pause           = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wstrb       = 4'b0000;
        mem_wdata       = '0;
        regs_write_en   = 1'b0;
        regs_write_addr = 5'd0;
        regs_write_data = '0;
        misalign_err    = 1'b0;
        bus_err         = 1'b0;
        case (r_state)
            S_IDLE: pause = req_valid;
            S_BUSY: begin
                pause    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = r_write;
                mem_addr = {r_addr[XLEN-1:2], 2'b00};
                if (r_write) begin
                    case (r_funct3[1:0])
                        2'b00: begin
                            mem_wstrb = 4'b0001 << r_addr[1:0];
                            mem_wdata = {4{r_wdata[7:0]}};
                        end
                        2'b01: begin
                            mem_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                            mem_wdata = {2{r_wdata[15:0]}};
                        end
                        default: begin
                            mem_wstrb = 4'b1111;
                            mem_wdata = r_wdata;
                        end
                    endcase
                end
            end
            S_DONE: begin
                misalign_err = r_err;
`ifdef LSU_TIMEOUT_EN
                bus_err = r_bus_err;
                if (!r_write && !r_err && !r_bus_err && r_rd != 5'd0) begin
`else
                if (!r_write && !r_err && r_rd != 5'd0) begin
`endif
                    regs_write_en   = 1'b1;
                    regs_write_addr = r_rd;
                    regs_write_data = w_load;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misalignment, mid-access reset and the BUSY wait limit.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 time units after it.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        pause;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        misalign_err;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    lsu #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .pause(pause),
        .regs_write_en(regs_write_en), .regs_write_addr(regs_write_addr),
        .regs_write_data(regs_write_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
    endtask

    // Accept, one BUSY cycle with mem_ready, then DONE.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic exp_en, input logic [31:0] exp_data);
        tick();
        present(1'b0, f3, addr, 32'd0, rd);
        #1;
        check({tag, "_c0_pause"}, {31'd0, pause}, 32'd1);
        check({tag, "_c0_memreq"}, {31'd0, mem_req}, 32'd0);
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = rdata;
        #1;
        check({tag, "_c1_pause"}, {31'd0, pause}, 32'd1);
        check({tag, "_c1_memreq"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_c1_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_c1_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        #1;
        check({tag, "_c2_pause"}, {31'd0, pause}, 32'd0);
        check({tag, "_c2_wen"}, {31'd0, regs_write_en}, {31'd0, exp_en});
        if (exp_en) begin
            check({tag, "_c2_waddr"}, {27'd0, regs_write_addr}, {27'd0, rd});
            check({tag, "_c2_wdata"}, regs_write_data, exp_data);
        end
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        tick();
        present(1'b1, f3, addr, wdata, 5'd9);
        #1;
        check({tag, "_c0_pause"}, {31'd0, pause}, 32'd1);
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        #1;
        check({tag, "_c1_memreq"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_c1_we"}, {31'd0, mem_we}, 32'd1);
        check({tag, "_c1_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_c1_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_strb});
        check({tag, "_c1_wdata"}, mem_wdata, exp_wdata);
        tick();
        mem_ready = 1'b0;
        #1;
        check({tag, "_c2_wen"}, {31'd0, regs_write_en}, 32'd0);
        check({tag, "_c2_memreq"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_c2_wdata0"}, mem_wdata, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        present(1'b0, 3'b010, 32'd0, 32'd0, 5'd0);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;

        // Reset state
        repeat (2) tick();
        #1;
        check("rst_pause", {31'd0, pause}, 32'd0);
        check("rst_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_wen", {31'd0, regs_write_en}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_buserr", {31'd0, bus_err}, 32'd0);
        rst = 1'b1;

        // Loads with extension
        do_load("lw", 3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        do_load("lb", 3'b000, 32'h103, 5'd6, 32'h80112233, 1'b1, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 5'd6, 32'h80112233, 1'b1, 32'h00000080);
        do_load("lh", 3'b001, 32'h102, 5'd7, 32'h80112233, 1'b1, 32'hFFFF8011);
        do_load("lhu0", 3'b101, 32'h100, 5'd8, 32'h80112233, 1'b1, 32'h00002233);
        do_load("lb_b1", 3'b000, 32'h101, 5'd3, 32'h80112233, 1'b1, 32'h00000022);
        do_load("lw_rd0", 3'b010, 32'h100, 5'd0, 32'h12345678, 1'b0, 32'd0);

        // Stores and lane steering
        do_store("sb", 3'b000, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
        do_store("sh", 3'b001, 32'h202, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
        do_store("sh_lo", 3'b001, 32'h200, 32'h00001234, 4'b0011, 32'h12341234);
        do_store("sw", 3'b010, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        // Misaligned word load: no bus access, one-cycle error pulse
        tick();
        present(1'b0, 3'b010, 32'h102, 32'd0, 5'd4);
        #1;
        check("mis_c0_pause", {31'd0, pause}, 32'd1);
        check("mis_c0_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check("mis_c1_err", {31'd0, misalign_err}, 32'd1);
        check("mis_c1_memreq", {31'd0, mem_req}, 32'd0);
        check("mis_c1_pause", {31'd0, pause}, 32'd0);
        check("mis_c1_wen", {31'd0, regs_write_en}, 32'd0);
        tick();
        #1;
        check("mis_c2_err", {31'd0, misalign_err}, 32'd0);

        // Illegal store funct3 and misaligned half store
        tick();
        present(1'b1, 3'b100, 32'h200, 32'd0, 5'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check("ill_st_err", {31'd0, misalign_err}, 32'd1);
        check("ill_st_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        present(1'b1, 3'b001, 32'h203, 32'd0, 5'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check("mis_sh_err", {31'd0, misalign_err}, 32'd1);

        // A request during DONE is ignored and accepted in the following IDLE cycle
        tick();
        present(1'b0, 3'b010, 32'h300, 32'd0, 5'd10);
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADCAFE;
        tick();
        mem_ready = 1'b0;
        present(1'b1, 3'b010, 32'h304, 32'h11223344, 5'd0);
        #1;
        check("done_pause", {31'd0, pause}, 32'd0);
        check("done_wdata", regs_write_data, 32'h0BADCAFE);
        tick();
        #1;
        check("redo_pause", {31'd0, pause}, 32'd1);
        check("redo_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("redo_wstrb", {28'd0, mem_wstrb}, 32'hF);
        check("redo_addr", mem_addr, 32'h304);
        tick();
        mem_ready = 1'b0;

        // Reset during an outstanding access
        tick();
        present(1'b0, 3'b010, 32'h100, 32'd0, 5'd7);
        tick();
        req_valid = 1'b0;
        #1;
        check("rmid_c1_memreq", {31'd0, mem_req}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rmid_c3_memreq", {31'd0, mem_req}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("rmid_c4_memreq", {31'd0, mem_req}, 32'd0);
        check("rmid_c4_pause", {31'd0, pause}, 32'd0);
        check("rmid_c4_wen", {31'd0, regs_write_en}, 32'd0);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        #1;
        check("rmid_c6_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        check("rmid_c7_wen", {31'd0, regs_write_en}, 32'd0);
        check("rmid_c7_err", {30'd0, misalign_err, bus_err}, 32'd0);

        // No mem_ready at all
        tick();
        present(1'b0, 3'b010, 32'h400, 32'd0, 5'd12);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        #1;
        check("tmo_c16_memreq", {31'd0, mem_req}, 32'd1);
`ifdef LSU_TIMEOUT_EN
        tick();
        #1;
        check("tmo_buserr", {31'd0, bus_err}, 32'd1);
        check("tmo_wen", {31'd0, regs_write_en}, 32'd0);
        check("tmo_pause", {31'd0, pause}, 32'd0);
        check("tmo_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        #1;
        check("tmo_after_buserr", {31'd0, bus_err}, 32'd0);
        check("tmo_after_pause", {31'd0, pause}, 32'd0);
`else
        for (int i = 0; i < 24; i++) tick();
        #1;
        check("hang_pause", {31'd0, pause}, 32'd1);
        check("hang_memreq", {31'd0, mem_req}, 32'd1);
        check("hang_buserr", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("hang_rst_memreq", {31'd0, mem_req}, 32'd0);
`endif

        // Back to normal after the stuck access
        do_load("lw_final", 3'b010, 32'h108, 5'd31, 32'h55AA55AA, 1'b1, 32'h55AA55AA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of ex; consumes ex's memory request (address, store data, access type) and drives the data-memory bus.
- Returns load results to regs via the register write port.
- Holds pc/ifu via pause while an access is outstanding.
- Multi-cycle: memory may take any number of cycles to assert mem_ready.

Parameters:
XLEN, 32, data/address width; must match `XLEN_WIDTH
TIMEOUT, 16, max cycles waiting for mem_ready (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets on a clk rising edge)
req_valid  input  1  ex presents a memory op this cycle
req_write  input  1  1=store, 0=load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  XLEN  effective byte address
req_wdata  input  XLEN  store data (rs2)
req_rd  input  5  load destination register
pause  output  1  stall pc/ifu/id/ex
regs_write_en  output  1  load writeback strobe
regs_write_addr  output  5  writeback rd
regs_write_data  output  XLEN  extended load data
mem_req  output  1  bus request, held until mem_ready
mem_we  output  1  bus write
mem_addr  output  XLEN  word-aligned address ({req_addr[XLEN-1:2],2'b00})
mem_wstrb  output  4  byte lane enables
mem_wdata  output  XLEN  lane-replicated store data
mem_ready  input  1  bus completes access this cycle
mem_rdata  input  XLEN  read word, valid with mem_ready
misalign_err  output  1  one-cycle pulse, misaligned/illegal access
bus_err  output  1  one-cycle pulse, bus timeout

Behaviour:
- Reset (rst==0 at edge): state IDLE; all registered outputs 0; captured request cleared. Applies mid-access: mem_req drops the cycle after the reset edge, no writeback, no error pulse.
- States: IDLE, BUSY, DONE.
- IDLE: pause = req_valid (combinational).
  - On req_valid, capture addr/wdata/funct3/rd/write.
  - Legal request -> BUSY.
  - Illegal request -> DONE with misalign_err. Illegal means word access with addr[1:0]!=0, half access with addr[0]!=0, or funct3 not in {000,001,010,100,101} (load) / {000,001,010} (store).
- BUSY: mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata stable; pause=1.
  - On mem_ready: capture mem_rdata -> DONE. mem_ready in the same cycle BUSY is entered counts.
- DONE (exactly 1 cycle): pause=0; mem_req=0.
  - Load without error and rd!=0: regs_write_en=1, regs_write_addr=rd, regs_write_data=extended data.
  - Stores, errors, or rd==0: regs_write_en=0.
  - Next state IDLE. A req_valid seen during DONE is ignored; ex re-presents it in the following IDLE cycle, which pause timing guarantees.
- Minimum access: accept (cycle 0) -> BUSY with mem_ready (cycle 1) -> DONE/writeback (cycle 2).
- Store lanes:
  - SB: wstrb = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 (addr[1]=0) or 1100; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- mem_wstrb is 0 for loads.
- mem_addr/mem_wdata are 0 whenever mem_req=0.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - Counter clears on BUSY entry and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT, the access aborts: -> DONE with bus_err=1 for that cycle and no writeback.
  - mem_ready in the same cycle as timeout wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Test Plan:
- LW addr=0x100, mem_ready 1 cycle after accept, rdata=0xDEADBEEF -> pause high 2 cycles; regs_write_en pulse at cycle 2 with rd=5, data=0xDEADBEEF.
- LB addr=0x103, rdata=0x80112233 -> data=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x102 -> 0xFFFF8011.
- SB addr=0x201, wdata=0x000000A5 -> mem_we=1, wstrb=0010, mem_wdata=0xA5A5A5A5, mem_addr=0x200, no writeback. SH addr=0x202 -> wstrb=1100.
- LW addr=0x102 -> no mem_req; misalign_err pulse; pause high 1 cycle; regs_write_en=0.
- mem_ready delayed 5 cycles, rst=0 asserted at cycle 3 -> mem_req low from cycle 4, state IDLE, no writeback or error.
- With LSU_TIMEOUT_EN, TIMEOUT=16, mem_ready never asserted -> bus_err pulse after 16 BUSY cycles, then IDLE. Without the macro -> pause stays high.
